// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall vector
// layout, the per-source stall encodings and the FSM state type.
package pipe_ctrl_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ENC_ID  = 6'b000111;
    localparam logic [5:0] STALL_ENC_EX  = 6'b001111;
    localparam logic [5:0] STALL_ENC_MEM = 6'b011111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles (saturating) and raises a
// sticky timeout flag that only reset clears.
module stall_wdog #(
    parameter int WDOG_LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    output logic timeout_o
);
    localparam int W = $clog2(WDOG_LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!stall_i) begin
            cnt_d = '0;
        end else if (cnt_q != W'(WDOG_LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Flag is set on the same edge the count lands on the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | (cnt_d == W'(WDOG_LIMIT));
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges ID/EX/MEM stall requests with
// exception flushes, deferring a flush while a MEM transaction is in flight.
//
// state | meaning
// RUN   | normal operation, stalls by priority mem > ex > id
// PEND  | flush accepted during MEM wait, held until MEM completes
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 1023,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             flush_req,
    input  logic [31:0]      exc_new_pc,
    input  logic             cnt_clr,
    output logic [5:0]       stall,
    output logic [4:0]       bubble,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             pend_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);
    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_inc;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = '0;
        pend_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    if (stallreq_mem) begin
                        stall   = STALL_ENC_MEM;
                        pc_d    = exc_new_pc;
                        state_d = ST_PEND;
                    end else begin
                        flush  = 1'b1;
                        new_pc = exc_new_pc;
                    end
                end else if (stallreq_mem) begin
                    stall = STALL_ENC_MEM;
                end else if (stallreq_ex) begin
                    stall = STALL_ENC_EX;
                end else if (stallreq_id) begin
                    stall = STALL_ENC_ID;
                end
            end
            ST_PEND: begin
                // First exception wins: later flush_req and ex/id requests are ignored.
                pend_flush = 1'b1;
                new_pc     = pc_q;
                if (stallreq_mem) begin
                    stall = STALL_ENC_MEM;
                end else begin
                    flush   = 1'b1;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        bubble = '0;
        if (!flush) begin
            for (int i = 0; i < 5; i++) begin
                bubble[i] = stall[i] & ~stall[i+1];
            end
        end
    end

    assign stall_inc = stall[STALL_PC] & ~flush;
    assign cnt_d     = cnt_clr ? '0 : cnt_q + CNT_W'(stall_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    stall_wdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stall_inc),
        .timeout_o(stall_timeout)
    );

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;
    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst, stallreq_id, stallreq_ex, stallreq_mem, flush_req, cnt_clr;
    logic [31:0] exc_new_pc;
    logic [5:0]  stall;
    logic [4:0]  bubble;
    logic        flush, pend_flush, stall_timeout;
    logic [31:0] new_pc, stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.WDOG_LIMIT(LIM), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem), .flush_req(flush_req), .exc_new_pc(exc_new_pc),
        .cnt_clr(cnt_clr), .stall(stall), .bubble(bubble), .flush(flush),
        .new_pc(new_pc), .pend_flush(pend_flush), .stall_cnt(stall_cnt),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: a pending-exception flag with its PC, a stall total,
    // a run length of consecutive stalled cycles and a sticky timeout.
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          m_run;
    bit          m_to;

    function automatic void expect_now(output logic [5:0] s, output logic [4:0] b,
                                       output logic f, output logic [31:0] np,
                                       output logic pf);
        int depth;
        depth = 0;
        f = 1'b0;
        np = 32'h0;
        pf = m_pend;
        if (m_pend) begin
            np = m_pc;
            if (stallreq_mem) depth = 5;
            else f = 1'b1;
        end else if (flush_req) begin
            if (stallreq_mem) depth = 5;
            else begin f = 1'b1; np = exc_new_pc; end
        end else if (stallreq_mem) depth = 5;
        else if (stallreq_ex) depth = 4;
        else if (stallreq_id) depth = 3;
        // A stall of depth d holds the d stages nearest the front of the pipe.
        s = 6'((1 << depth) - 1);
        b = '0;
        if (!f && depth > 0) b[depth-1] = 1'b1;
    endfunction

    logic [5:0]  md_s;
    logic [4:0]  md_b;
    logic        md_f, md_pf;
    logic [31:0] md_np;

    always @(posedge clk) begin
        expect_now(md_s, md_b, md_f, md_np, md_pf);
        if (rst) begin
            m_pend = 0; m_pc = 0; m_cnt = 0; m_run = 0; m_to = 0;
        end else begin
            if (cnt_clr) m_cnt = 0;
            else if (md_s[0] && !md_f) m_cnt = m_cnt + 1;
            if (md_s[0] && !md_f) begin
                if (m_run < LIM) m_run = m_run + 1;
            end else m_run = 0;
            if (m_run == LIM) m_to = 1;
            if (m_pend) begin
                if (!stallreq_mem) m_pend = 0;
            end else if (flush_req && stallreq_mem) begin
                m_pend = 1;
                m_pc = exc_new_pc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic id, input logic ex, input logic mem,
                          input logic fr, input logic [31:0] pc, input logic clr);
        stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        flush_req = fr; exc_new_pc = pc; cnt_clr = clr;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 32'h0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        #4;
        checks++;
        if ({stall, bubble, flush, new_pc, pend_flush, stall_cnt, stall_timeout} !== '0) begin
            errors++;
            $display("FAIL reset: stall=%b bubble=%b flush=%b new_pc=%h pend=%b cnt=%0d to=%b, want all 0",
                     stall, bubble, flush, new_pc, pend_flush, stall_cnt, stall_timeout);
        end
        tick();
    endtask

    task automatic test_id_stall();
        reset_dut();
        set_in(1, 0, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (stall !== 6'b000111 || bubble !== 5'b00100) begin
            errors++;
            $display("FAIL id_stall: stall=%b bubble=%b, want 000111/00100", stall, bubble);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL id_stall_cnt: got %0d want 1", stall_cnt);
        end
        tick();
    endtask

    task automatic test_ex_stall();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 0, 0, 32'h0, 0);
            #4;
            checks++;
            if (stall !== 6'b001111 || bubble !== 5'b01000) begin
                errors++;
                $display("FAIL ex_stall[%0d]: stall=%b bubble=%b, want 001111/01000", k, stall, bubble);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL ex_stall_cnt: got %0d want 3", stall_cnt);
        end
        tick();
    endtask

    task automatic test_flush_run();
        reset_dut();
        set_in(0, 1, 0, 1, 32'hBFC00380, 0);
        #4;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00380 || stall !== 6'b0 || bubble !== 5'b0) begin
            errors++;
            $display("FAIL flush_run: flush=%b new_pc=%h stall=%b bubble=%b, want 1/bfc00380/0/0",
                     flush, new_pc, stall, bubble);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (stall_cnt !== 32'd0 || pend_flush !== 1'b0 || new_pc !== 32'h0) begin
            errors++;
            $display("FAIL flush_run_after: cnt=%0d pend=%b new_pc=%h, want 0/0/0", stall_cnt, pend_flush, new_pc);
        end
        tick();
    endtask

    task automatic test_pend_flush();
        reset_dut();
        set_in(0, 0, 1, 1, 32'h80000180, 0);
        #4;
        checks++;
        if (flush !== 1'b0 || stall !== 6'b011111 || pend_flush !== 1'b0) begin
            errors++;
            $display("FAIL pend_entry: flush=%b stall=%b pend=%b, want 0/011111/0", flush, stall, pend_flush);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 1, 1, (k == 1), 32'h0, 0);
            #4;
            checks++;
            if (pend_flush !== 1'b1 || stall !== 6'b011111 || flush !== 1'b0 || new_pc !== 32'h80000180) begin
                errors++;
                $display("FAIL pend_hold[%0d]: pend=%b stall=%b flush=%b new_pc=%h", k, pend_flush, stall, flush, new_pc);
            end
            tick();
        end
        set_in(1, 1, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'h80000180 || stall !== 6'b0 || bubble !== 5'b0) begin
            errors++;
            $display("FAIL pend_release: flush=%b new_pc=%h stall=%b bubble=%b, want 1/80000180/0/0",
                     flush, new_pc, stall, bubble);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (pend_flush !== 1'b0 || flush !== 1'b0 || new_pc !== 32'h0 || stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL pend_back_run: pend=%b flush=%b new_pc=%h cnt=%0d, want 0/0/0/5",
                     pend_flush, flush, new_pc, stall_cnt);
        end
        tick();
    endtask

    task automatic test_wdog();
        reset_dut();
        for (int k = 0; k < 20; k++) begin
            set_in(0, 0, 1, 0, 32'h0, 0);
            #4;
            checks++;
            if (stall_timeout !== (k >= LIM)) begin
                errors++;
                $display("FAIL wdog_stall[%0d]: to=%b want %b", k, stall_timeout, (k >= LIM));
            end
            tick();
        end
        set_in(0, 0, 0, 0, 32'h0, 1);
        #4;
        checks++;
        if (stall_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wdog_release: to=%b want 1", stall_timeout);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (stall_timeout !== 1'b1 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL wdog_after_clr: to=%b cnt=%0d want 1/0", stall_timeout, stall_cnt);
        end
        reset_dut();
        #4;
        checks++;
        if (stall_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_after_rst: to=%b want 0", stall_timeout);
        end
        tick();
    endtask

    task automatic test_rst_pend();
        reset_dut();
        set_in(0, 0, 1, 1, 32'h12345678, 0);
        tick();
        set_in(0, 0, 1, 0, 32'h0, 0);
        #4;
        checks++;
        if (pend_flush !== 1'b1) begin
            errors++;
            $display("FAIL rst_pend_entry: pend=%b want 1", pend_flush);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #4;
        checks++;
        if (pend_flush !== 1'b0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_pend_cleared: pend=%b cnt=%0d want 0/0", pend_flush, stall_cnt);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #4;
        checks++;
        if (flush !== 1'b0 || new_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_pend_no_flush: flush=%b new_pc=%h want 0/0", flush, new_pc);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0]  es;
        logic [4:0]  eb;
        logic        ef, epf;
        logic [31:0] enp;
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_in($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
                   $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10,
                   $urandom, $urandom_range(0, 99) < 4);
            #4;
            expect_now(es, eb, ef, enp, epf);
            checks++;
            if (stall !== es || bubble !== eb || flush !== ef || new_pc !== enp || pend_flush !== epf) begin
                errors++;
                $display("FAIL rand_comb[%0d]: got s=%b b=%b f=%b pc=%h p=%b want s=%b b=%b f=%b pc=%h p=%b",
                         n, stall, bubble, flush, new_pc, pend_flush, es, eb, ef, enp, epf);
            end
            checks++;
            if (stall_cnt !== m_cnt || stall_timeout !== m_to) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got cnt=%0d to=%b want cnt=%0d to=%b",
                         n, stall_cnt, stall_timeout, m_cnt, m_to);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 32'h0, 0);
        test_reset();
        test_id_stall();
        test_ex_stall();
        test_flush_run();
        test_pend_flush();
        test_wdog();
        test_rst_pend();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the GeMIPS 5-stage core.
- Merges stall requests from ID (load-use), EX (multi-cycle mult/div) and MEM (bus wait) with exception flush requests.
- Drives per-stage hold and bubble controls to every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC.
- Defers an exception flush while a memory transaction is in flight, and keeps a stall performance counter and a stall watchdog.

Parameters:
- WDOG_LIMIT, 1023: consecutive stalled cycles after which stall_timeout is set.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- stallreq_id  input  1  ID load-use hazard
- stallreq_ex  input  1  EX multi-cycle unit busy
- stallreq_mem  input  1  MEM bus transaction not complete
- flush_req  input  1  exception/eret, single-cycle pulse
- exc_new_pc  input  32  handler/return PC, valid with flush_req
- cnt_clr  input  1  clears stall_cnt
- stall  output  6  hold per stage: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
- bubble  output  5  bubble[i] = stall[i] & ~stall[i+1]; the downstream register loads a NOP
- flush  output  1  clear all pipeline registers, one-cycle pulse
- new_pc  output  32  PC to load when flush=1
- pend_flush  output  1  flush deferred, waiting for MEM
- stall_cnt  output  CNT_W  total cycles with stall[0]=1
- stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset drives state=RUN, stall=0, bubble=0, flush=0, new_pc=0, pend_flush=0, stall_cnt=0, stall_timeout=0, watchdog counter=0, latched PC=0.
- Reset has priority over everything, including mid-stall and mid-PEND; a pending flush is discarded.
- stall, bubble, flush and new_pc are combinational from inputs and state (zero latency; required for load-use). Counters and state are registered.
- Stall encoding in RUN, with priority mem > ex > id:
  - stallreq_mem=1: 6'b011111
  - else stallreq_ex=1: 6'b001111
  - else stallreq_id=1: 6'b000111
  - else 6'b000000
- bubble is derived from stall only; it is forced to 0 whenever flush=1.
- FSM has two states, RUN and PEND.
- RUN, flush_req=1, stallreq_mem=0:
  - flush=1 and new_pc=exc_new_pc this cycle.
  - stall=0, overriding the ex/id requests.
  - Stay in RUN.
- RUN, flush_req=1, stallreq_mem=1:
  - flush=0, stall=6'b011111.
  - Latch exc_new_pc; next state PEND.
- PEND:
  - pend_flush=1 and new_pc=latched PC.
  - While stallreq_mem=1: stall=6'b011111, flush=0.
  - First cycle stallreq_mem=0: flush=1, stall=0, next state RUN.
  - stallreq_ex, stallreq_id and further flush_req are ignored in PEND (first exception wins).
- RUN without flush_req: new_pc=0.
- stall_cnt:
  - Increments each cycle stall[0]=1 and flush=0; wraps modulo 2^CNT_W.
  - cnt_clr has priority over increment; cnt_clr and increment in the same cycle gives 0.
- Watchdog:
  - Counts consecutive cycles with stall[0]=1, saturating at WDOG_LIMIT.
  - Clears on any cycle with stall[0]=0 or flush=1.
  - When the count reaches WDOG_LIMIT, stall_timeout is set the following cycle and stays 1 until rst (cnt_clr does not clear it).
- Simultaneous stallreq_id and stallreq_ex: EX encoding wins. The ID instruction is held in if_id/id_ex, and bubble[3] goes to ex_mem.

Decomposition:
- Shared package/include:
  - stall vector bit indices (STALL_PC..STALL_WB)
  - encodings STALL_NONE/ID/EX/MEM (6'b000000, 000111, 001111, 011111)
  - FSM state constants
- One natural sub-module, stall_wdog: watchdog counter plus sticky flag, parameterised by WDOG_LIMIT.
- The stall counter stays inline.

Test Plan:
- stallreq_id=1 for 1 cycle -> stall=6'b000111, bubble=5'b00100 that cycle; stall_cnt=1 afterwards.
- stallreq_ex=1 for 3 cycles with stallreq_id=1 -> stall=6'b001111 all 3 cycles, bubble=5'b01000; stall_cnt=3.
- flush_req=1, exc_new_pc=32'hBFC00380, no stall, stallreq_ex=1 -> same cycle flush=1, new_pc=32'hBFC00380, stall=0, bubble=0.
- flush_req=1 (exc_new_pc=32'h80000180) while stallreq_mem=1 for 4 more cycles, then a second flush_req with 32'h0 during PEND -> pend_flush=1 and stall=6'b011111 for 4 cycles; flush=1 with new_pc=32'h80000180 on the cycle stallreq_mem drops; back in RUN.
- WDOG_LIMIT=8, stallreq_mem held 20 cycles -> stall_timeout=1 from the cycle after the 8th stalled cycle, still 1 after release and after cnt_clr; 0 only after rst.
- rst asserted during PEND -> next cycle pend_flush=0, no flush pulse after stallreq_mem drops, stall_cnt=0.
